// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR ADC controller slice.
//   sar_state_e  : controller state (IDLE, SAMPLE, TRIAL, DONE)
//   SYNC_STAGES  : depth of the comparator synchronizer
// -----------------------------------------------------------------------------
package sar_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_TRIAL  = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_e;

endpackage : sar_pkg

// File: rtl/sar_sync2.sv
// -----------------------------------------------------------------------------
// sar_sync2
// Generic two-flop synchronizer for asynchronous single-bit tile inputs.
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset (flops clear to 0)
//   i_d    in   asynchronous input
//   o_q    out  synchronized output, SYNC_STAGES cycles of latency
// -----------------------------------------------------------------------------
module sar_sync2
    import sar_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule : sar_sync2

// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation controller for the SAR ADC macro. Tracks the input
// for SAMPLE_CYC cycles, then resolves one bit per T = SETTLE_CYC+2 cycles,
// MSB first, and publishes the code with a one-cycle valid pulse.
// Ports:
//   clk        in   conversion clock
//   rst_n      in   asynchronous active-low reset
//   start      in   conversion request (level, looked at only in IDLE)
//   cmp_in     in   asynchronous comparator output, 1 = Vin >= Vdac
//   sample_en  out  sampling switch enable
//   dac_code   out  trial code for the capacitive DAC
//   busy       out  high from SAMPLE through DONE
//   result     out  last completed conversion, held until the next DONE
//   valid      out  one-cycle pulse in the cycle result updates
//   dbg_state  out  current controller state
// Request protocol: start has no handshake partner. It is sampled only while
// the controller sits in IDLE; a 1 there launches a conversion next cycle, and
// any start seen in other states is dropped (nothing is queued).
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS      = 4,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             valid,
    output sar_state_e       dbg_state
);

    // Cycles per bit: settling plus the synchronizer delay.
    localparam int T       = SETTLE_CYC + 2;
    localparam int CNT_MAX = (SAMPLE_CYC > T) ? SAMPLE_CYC : T;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int KW      = $clog2(NBITS);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] TRIAL_LAST  = CNT_W'(T - 1);
    localparam logic [KW-1:0]    K_MSB       = KW'(NBITS - 1);
    localparam logic [NBITS-1:0] MIDSCALE    = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [KW-1:0]    r_k;
    logic [NBITS-1:0] r_code;
    logic [NBITS-1:0] r_result;
    logic             r_sample_en;
    logic             r_busy;
    logic             r_valid;

    sar_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic [NBITS-1:0] w_code_nxt;
    logic [NBITS-1:0] w_bit;
    logic [NBITS-1:0] w_result_nxt;
    logic             w_sample_en_nxt;
    logic             w_busy_nxt;
    logic             w_valid_nxt;
    logic             w_cmp_s;

    sar_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (cmp_in),
        .o_q   (w_cmp_s)
    );

    // State register and conversion datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // One-hot mask of the bit currently under trial.
    assign w_bit = NBITS'(1) << r_k;

    // Next-state and datapath logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_code_nxt  = r_code;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_code_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (r_cnt == SAMPLE_LAST) begin
                    w_state_nxt = ST_TRIAL;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = K_MSB;
                    w_code_nxt  = MIDSCALE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_TRIAL: begin
                if (r_cnt == TRIAL_LAST) begin
                    w_cnt_nxt = '0;
                    // Resolve bit k from the comparator and, if a lower bit
                    // remains, raise it as the next trial (w_bit >> 1 is 0
                    // when k = 0, so the LSB step needs no special case).
                    w_code_nxt = (r_code & ~w_bit) | (w_cmp_s ? w_bit : '0) | (w_bit >> 1);
                    if (r_k != '0) begin
                        w_k_nxt = r_k - 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = '0;
            end
        endcase
    end

    // Output decode from the upcoming state, so the flops below present each
    // output in the same cycle as the state it belongs to.
    always_comb begin
        w_sample_en_nxt = (w_state_nxt == ST_SAMPLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_valid_nxt     = (w_state_nxt == ST_DONE);
        w_result_nxt    = (w_state_nxt == ST_DONE) ? w_code_nxt : r_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_en <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_result    <= '0;
        end else begin
            r_sample_en <= w_sample_en_nxt;
            r_busy      <= w_busy_nxt;
            r_valid     <= w_valid_nxt;
            r_result    <= w_result_nxt;
        end
    end

    assign sample_en = r_sample_en;
    assign dac_code  = r_code;
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule : sar_adc_ctrl

// File: tb/tb_sar_adc_ctrl.sv
module tb_sar_adc_ctrl;
  import sar_pkg::*;

  localparam int NB     = 4;
  localparam int S      = 4;
  localparam int SET    = 2;
  localparam int T      = SET + 2;
  localparam int DONE_T = 1 + S + NB * T;

  typedef struct packed {
    logic [3:0]      vin;
    logic [3:0]      res;
    logic [3:0][3:0] tr;   // tr[j] = j-th trial code, MSB trial first
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          cmp_in;
  logic          sample_en;
  logic [NB-1:0] dac_code;
  logic          busy;
  logic [NB-1:0] result;
  logic          valid;
  sar_state_e    dbg_state;

  int            vin;
  logic          glitch;
  int            n_checks;
  int            n_fail;
  int            cyc;
  logic [NB-1:0] last_result;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  // Behavioural comparator: zero-delay, optionally forced low for a glitch.
  assign cmp_in = glitch ? 1'b0 : (vin >= int'(dac_code));

  sar_adc_ctrl #(
    .NBITS      (NB),
    .SAMPLE_CYC (S),
    .SETTLE_CYC (SET)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmp_in    (cmp_in),
    .sample_en (sample_en),
    .dac_code  (dac_code),
    .busy      (busy),
    .result    (result),
    .valid     (valid),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s cycle %0d: got %0d, expected %0d", name, field, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference model: plain binary search over the code range.
  task automatic model(input int v, output logic [3:0][3:0] tr, output logic [3:0] res);
    int code;
    int trial;
    code = 0;
    for (int j = 0; j < NB; j++) begin
      trial = code + (1 << (NB - 1 - j));
      tr[j] = 4'(trial);
      if (v >= trial) code = trial;
    end
    res = 4'(code);
  endtask

  task automatic chk_idle(input string name);
    chk(name, "sample_en", sample_en, 0);
    chk(name, "busy", busy, 0);
    chk(name, "valid", valid, 0);
    chk(name, "dac_code", dac_code, 0);
    chk(name, "result", result, last_result);
    chk(name, "state", dbg_state, ST_IDLE);
  endtask

  // ---------------- driver: one conversion, checked every cycle ----------------
  // Call right after next_cycle(); that cycle is t = 0 (IDLE with start = 1).
  task automatic run_conv(input string name, input int v, input logic [3:0][3:0] tr,
                          input logic [3:0] res, input bit hold, input int pa, input int pb,
                          input int glitch_t, input int abort_t);
    logic [3:0] e_dac;
    logic [3:0] e_res;
    vin   = v;
    start = 1'b1;
    for (int t = 0; t <= DONE_T; t++) begin
      if (t > 0) begin
        next_cycle();
        start  = hold || (t == pa) || (t == pb);
        glitch = (t == glitch_t);
      end
      if (t >= S + 1 && t <= S + NB * T) e_dac = tr[(t - S - 1) / T];
      else if (t == DONE_T)              e_dac = res;
      else                               e_dac = 4'd0;
      e_res = (t == DONE_T) ? res : last_result;
      chk(name, "sample_en", sample_en, (t >= 1 && t <= S) ? 1 : 0);
      chk(name, "busy", busy, (t >= 1 && t <= DONE_T) ? 1 : 0);
      chk(name, "valid", valid, (t == DONE_T) ? 1 : 0);
      chk(name, "dac_code", dac_code, e_dac);
      chk(name, "result", result, e_res);
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        last_result = '0;
        glitch      = 1'b0;
        start       = 1'b0;
        chk_idle({name, "_rst"});
        return;
      end
    end
    glitch      = 1'b0;
    last_result = res;
  endtask

  vec_t vecs [5];

  initial begin
    logic [3:0][3:0] tr;
    logic [3:0]      res;

    vecs[0] = '{vin: 4'd11, res: 4'd11, tr: {4'd11, 4'd10, 4'd12, 4'd8}};
    vecs[1] = '{vin: 4'd0,  res: 4'd0,  tr: {4'd1,  4'd2,  4'd4,  4'd8}};
    vecs[2] = '{vin: 4'd15, res: 4'd15, tr: {4'd15, 4'd14, 4'd12, 4'd8}};
    vecs[3] = '{vin: 4'd6,  res: 4'd6,  tr: {4'd7,  4'd6,  4'd4,  4'd8}};
    vecs[4] = '{vin: 4'd5,  res: 4'd5,  tr: {4'd5,  4'd6,  4'd4,  4'd8}};

    rst_n = 1'b0; start = 1'b0; vin = 0; glitch = 1'b0;
    n_checks = 0; n_fail = 0; cyc = 0; last_result = '0;

    #12;
    chk_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    chk_idle("post_reset");

    // Table-driven conversions.
    foreach (vecs[i]) begin
      next_cycle();
      run_conv($sformatf("vec%0d", i), vecs[i].vin, vecs[i].tr, vecs[i].res, 1'b0, -1, -1, -1, -1);
      next_cycle();
      chk_idle($sformatf("vec%0d_after", i));
    end

    // Randomized conversions against the binary-search model.
    for (int i = 0; i < 20; i++) begin
      int v;
      v = $urandom_range(0, 15);
      model(v, tr, res);
      next_cycle();
      run_conv($sformatf("rand%0d", i), v, tr, res, 1'b0, -1, -1, -1, -1);
      next_cycle();
      chk_idle($sformatf("rand%0d_after", i));
    end

    // start held high: back-to-back conversions, one IDLE cycle between.
    next_cycle();
    model(3, tr, res);
    run_conv("b2b_a", 3, tr, res, 1'b1, -1, -1, -1, -1);
    next_cycle();
    model(9, tr, res);
    run_conv("b2b_b", 9, tr, res, 1'b1, -1, -1, -1, -1);
    next_cycle();
    start = 1'b0;
    chk_idle("b2b_gap");
    next_cycle();
    chk_idle("b2b_end");

    // Extra start pulses during a conversion are ignored.
    next_cycle();
    model(11, tr, res);
    run_conv("extra_start", 11, tr, res, 1'b0, 5, 15, -1, -1);
    next_cycle();
    chk_idle("extra_start_gap");
    next_cycle();
    chk_idle("extra_start_noq");

    // Comparator glitch at counter 0 of bit 2 is outside the decision window.
    next_cycle();
    run_conv("glitch", 15, vecs[2].tr, 4'd15, 1'b0, -1, -1, S + T + 1, -1);
    next_cycle();
    chk_idle("glitch_after");

    // Reset mid-trial, then a fresh conversion.
    next_cycle();
    model(11, tr, res);
    run_conv("abort", 11, tr, res, 1'b0, -1, -1, -1, 12);
    next_cycle();
    chk_idle("abort_hold");
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    chk_idle("abort_release");
    next_cycle();
    run_conv("after_abort", 6, vecs[3].tr, 4'd6, 1'b0, -1, -1, -1, -1);
    next_cycle();
    chk_idle("after_abort_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
